// File: rtl/sparhixcel_ctrl_pkg.sv
// Shared control-plane types for the systolic array sequencing blocks.
package sparhixcel_ctrl_pkg;

  localparam int CNT_W_DEF = 8;

  // Loop levels, innermost first; the counter chain is built in this order.
  localparam int NUM_LVL = 3;
  localparam int LVL_CH  = 0;
  localparam int LVL_COL = 1;
  localparam int LVL_ROW = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/loop_level_counter.sv
// One level of the output loop nest: counts 0..max and wraps by comparison,
// so max = all-ones never relies on a carry-out.
module loop_level_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] max_i,
  output logic [W-1:0] count_o,
  output logic         at_max_o
);

  logic [W-1:0] count_q, count_d;

  assign at_max_o = (count_q == max_i);
  assign count_o  = count_q;

  // Clear wins over step; a step at max wraps to zero.
  always_comb begin
    count_d = count_q;
    if (clr_i)     count_d = '0;
    else if (en_i) count_d = at_max_o ? '0 : count_q + 1'b1;
  end

  // Index register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) count_q <= '0;
    else          count_q <= count_d;
  end

endmodule

// File: rtl/conv_loop_scheduler.sv
// Row/col/channel loop sequencer for the PE array: latches a run config,
// emits one index tuple per non-stalled cycle, drains, then pulses done.
module conv_loop_scheduler
  import sparhixcel_ctrl_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             stall_i,
  input  logic [CNT_W-1:0] max_row_i,
  input  logic [CNT_W-1:0] max_col_i,
  input  logic [CNT_W-1:0] max_ch_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] row_o,
  output logic [CNT_W-1:0] col_o,
  output logic [CNT_W-1:0] ch_o,
  output logic             first_o,
  output logic             last_o,
  output logic             done_o
);

  // Final drain count value; only meaningful when DRAIN_CYCLES >= 1.
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

  sched_state_t state_q, state_d;
  logic [7:0]   drain_q, drain_d;

  logic [NUM_LVL-1:0][CNT_W-1:0] max_q;
  logic [NUM_LVL-1:0][CNT_W-1:0] cnt;
  logic [NUM_LVL-1:0]            at_max;
  logic [NUM_LVL-1:0]            lvl_en;

  logic accept;
  logic step;
  logic last_tuple;
  logic kill;
  logic cnt_clr;

  assign accept     = (state_q == IDLE) && start_i;
  // Abort outranks both stall and last-tuple detection: nothing is consumed.
  assign step       = (state_q == RUN) && !stall_i && !abort_i;
  assign last_tuple = step && (&at_max);
  assign kill       = abort_i && ((state_q == RUN) || (state_q == FLUSH));
  assign cnt_clr    = accept || last_tuple || kill;

  // Counter chain: an outer level steps only when every inner level wraps.
  genvar g;
  generate
    for (g = 0; g < NUM_LVL; g++) begin : g_lvl
      if (g == 0) begin : g_inner
        assign lvl_en[g] = step;
      end else begin : g_outer
        assign lvl_en[g] = step & (&at_max[g-1:0]);
      end
      loop_level_counter #(.W(CNT_W)) u_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (cnt_clr),
        .en_i    (lvl_en[g]),
        .max_i   (max_q[g]),
        .count_o (cnt[g]),
        .at_max_o(at_max[g])
      );
    end
  endgenerate

  // Run configuration is captured only on an accepted start.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      max_q <= '0;
    end else if (accept) begin
      max_q[LVL_ROW] <= max_row_i;
      max_q[LVL_COL] <= max_col_i;
      max_q[LVL_CH]  <= max_ch_i;
    end
  end

  // State and drain counter registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Next-state logic; the drain counter free-runs through stalls.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = RUN;
      end
      RUN: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (last_tuple) begin
          drain_d = '0;
          state_d = (DRAIN_CYCLES == 0) ? DONE : FLUSH;
        end
      end
      FLUSH: begin
        if (abort_i)                    state_d = IDLE;
        else if (drain_q == DRAIN_LAST) state_d = DONE;
        else                            drain_d = drain_q + 8'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_o  = (state_q != IDLE);
  assign valid_o = step;
  assign first_o = step && (cnt == '0);
  assign last_o  = last_tuple;
  assign done_o  = (state_q == DONE);
  assign row_o   = cnt[LVL_ROW];
  assign col_o   = cnt[LVL_COL];
  assign ch_o    = cnt[LVL_CH];

endmodule

// File: tb/tb_conv_loop_scheduler.sv
// Scoreboard bench for conv_loop_scheduler (CNT_W=8, DRAIN_CYCLES=4).
module tb_conv_loop_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0, stall = 1'b0;
  logic [7:0] max_row = '0, max_col = '0, max_ch = '0;
  logic       busy, valid, first, last, done;
  logic [7:0] row, col, ch;

  conv_loop_scheduler #(.CNT_W(8), .DRAIN_CYCLES(4)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .start_i  (start),
    .abort_i  (abort),
    .stall_i  (stall),
    .max_row_i(max_row),
    .max_col_i(max_col),
    .max_ch_i (max_ch),
    .busy_o   (busy),
    .valid_o  (valid),
    .row_o    (row),
    .col_o    (col),
    .ch_o     (ch),
    .first_o  (first),
    .last_o   (last),
    .done_o   (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] c;
    logic [7:0] h;
    logic       f;
    logic       l;
  } tup_t;

  tup_t exp_q[$];
  tup_t obs_q[$];
  tup_t held_q[$];

  int pass_cnt = 0;
  int total_cnt = 0;
  int last_cyc, done_cyc, done_cnt, end_cyc, abort_cyc, first_cyc;
  logic [7:0] end_r, end_c, end_h;
  bit timed_out;

  // Reference loop nest: channel innermost, then column, then row.
  task automatic push_expected(input int mr, input int mc, input int mh);
    tup_t t;
    exp_q.delete();
    for (int r = 0; r <= mr; r++)
      for (int c = 0; c <= mc; c++)
        for (int h = 0; h <= mh; h++) begin
          t.r = 8'(r); t.c = 8'(c); t.h = 8'(h);
          t.f = (r == 0) && (c == 0) && (h == 0);
          t.l = (r == mr) && (c == mc) && (h == mh);
          exp_q.push_back(t);
        end
  endtask

  // Start a run, then drive stall/abort/stray-start cycle by cycle and
  // record every consumed tuple until busy falls.
  task automatic run(input int mr, input int mc, input int mh,
                     input int stall_at, input int stall_len,
                     input int abort_at, input int abort_fl, input int glitch_at);
    int cyc;
    int rem;
    bit last_seen;
    tup_t t;
    cyc = 0; rem = stall_len; last_seen = 0;
    obs_q.delete(); held_q.delete();
    last_cyc = -1; done_cyc = -1; done_cnt = 0; abort_cyc = -1; first_cyc = -1;
    timed_out = 0;
    @(posedge clk); #1;
    max_row = 8'(mr); max_col = 8'(mc); max_ch = 8'(mh); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    max_row = 8'(mr + 1); max_col = 8'(mc + 1); max_ch = 8'(mh + 1);
    forever begin
      stall = (rem > 0) && !last_seen && (obs_q.size() == stall_at);
      if (stall) rem--;
      abort = (abort_cyc < 0) &&
              (((abort_at >= 0) && !last_seen && (obs_q.size() == abort_at)) ||
               ((abort_fl >= 0) && last_seen && (cyc == last_cyc + 1 + abort_fl)));
      if (abort) abort_cyc = cyc;
      start = (cyc == glitch_at);
      if (start) begin max_row = 8'd2; max_col = 8'd2; max_ch = 8'd2; end
      @(negedge clk);
      t.r = row; t.c = col; t.h = ch; t.f = first; t.l = last;
      if (valid) begin
        obs_q.push_back(t);
        if (first_cyc < 0) first_cyc = cyc;
        if (last) begin last_seen = 1; last_cyc = cyc; end
      end
      if (stall) begin t.f = valid; held_q.push_back(t); end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (!busy) break;
      if (cyc >= 3000) begin timed_out = 1; break; end
      @(posedge clk); #1;
      cyc++;
    end
    end_cyc = cyc; end_r = row; end_c = col; end_h = ch;
    stall = 1'b0; abort = 1'b0; start = 1'b0;
    total_cnt++;
    if (timed_out) $display("FAIL run_timeout busy still %0b after %0d cycles, required 0", busy, cyc);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    #2;
    total_cnt++;
    if ({busy, valid, first, last, done, row, col, ch} !== '0)
      $display("FAIL reset_outputs got %h required 0", {busy, valid, first, last, done, row, col, ch});
    else pass_cnt++;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({busy, valid, done, row, col, ch} !== '0)
      $display("FAIL reset_hold got %h required 0", {busy, valid, done, row, col, ch});
    else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    tup_t e, o;
    int i;
    push_expected(1, 1, 2);
    run(1, 1, 2, -1, 0, -1, -1, -1);
    total_cnt++;
    if (obs_q.size() != 12) $display("FAIL basic_count got %0d required 12", obs_q.size());
    else pass_cnt++;
    i = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total_cnt++;
      if (o !== e) $display("FAIL basic_tuple[%0d] got %h required %h", i, o, e);
      else pass_cnt++;
      i++;
    end
    total_cnt++;
    if (first_cyc !== 0) $display("FAIL basic_first_latency got %0d required 0", first_cyc);
    else pass_cnt++;
    total_cnt++;
    if (done_cnt !== 1 || done_cyc - last_cyc !== 5)
      $display("FAIL basic_done done_cnt %0d gap %0d required 1 and 5", done_cnt, done_cyc - last_cyc);
    else pass_cnt++;
    total_cnt++;
    if (end_cyc !== done_cyc + 1) $display("FAIL basic_busy_fall got %0d required %0d", end_cyc, done_cyc + 1);
    else pass_cnt++;
    total_cnt++;
    if ({end_r, end_c, end_h} !== '0) $display("FAIL basic_idle_idx got %h required 0", {end_r, end_c, end_h});
    else pass_cnt++;
  endtask

  task automatic test_stall();
    tup_t e, o;
    int i;
    push_expected(1, 1, 2);
    run(1, 1, 2, 4, 3, -1, -1, -1);
    total_cnt++;
    if (obs_q.size() != 12) $display("FAIL stall_count got %0d required 12", obs_q.size());
    else pass_cnt++;
    i = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total_cnt++;
      if (o !== e) $display("FAIL stall_tuple[%0d] got %h required %h", i, o, e);
      else pass_cnt++;
      i++;
    end
    total_cnt++;
    if (held_q.size() != 3) $display("FAIL stall_len got %0d required 3", held_q.size());
    else pass_cnt++;
    while (held_q.size() > 0) begin
      o = held_q.pop_front();
      total_cnt++;
      if ({o.r, o.c, o.h, o.f, o.l} !== {8'd0, 8'd1, 8'd1, 1'b0, 1'b0})
        $display("FAIL stall_hold got r%0d c%0d h%0d valid%0b required r0 c1 h1 valid0", o.r, o.c, o.h, o.f);
      else pass_cnt++;
    end
    total_cnt++;
    if (last_cyc !== 14 || done_cyc !== 19)
      $display("FAIL stall_done last %0d done %0d required 14 and 19", last_cyc, done_cyc);
    else pass_cnt++;
  endtask

  task automatic test_zero_max();
    tup_t e, o;
    push_expected(0, 0, 0);
    run(0, 0, 0, -1, 0, -1, -1, -1);
    total_cnt++;
    if (obs_q.size() != 1) $display("FAIL zero_count got %0d required 1", obs_q.size());
    else pass_cnt++;
    if (obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total_cnt++;
      if (o !== e) $display("FAIL zero_tuple got %h required %h", o, e);
      else pass_cnt++;
    end
    total_cnt++;
    if (done_cnt !== 1 || done_cyc !== 5) $display("FAIL zero_done cnt %0d cyc %0d required 1 and 5", done_cnt, done_cyc);
    else pass_cnt++;
  endtask

  task automatic test_wrap_255();
    tup_t e, o;
    int i, bad;
    push_expected(0, 1, 255);
    run(0, 1, 255, -1, 0, -1, -1, -1);
    total_cnt++;
    if (obs_q.size() != 512) $display("FAIL wrap_count got %0d required 512", obs_q.size());
    else pass_cnt++;
    i = 0; bad = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o !== e) begin
        if (bad == 0) $display("FAIL wrap_tuple[%0d] got %h required %h", i, o, e);
        bad++;
      end
      i++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL wrap_seq got %0d bad tuples required 0", bad);
    else pass_cnt++;
    total_cnt++;
    if (done_cyc !== 516) $display("FAIL wrap_done got %0d required 516", done_cyc);
    else pass_cnt++;
  endtask

  task automatic test_abort_run();
    tup_t e, o;
    int i, late_done;
    push_expected(1, 1, 2);
    run(1, 1, 2, -1, 0, 7, -1, -1);
    i = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0 && i < 7) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total_cnt++;
      if (o !== e) $display("FAIL abort_run_tuple[%0d] got %h required %h", i, o, e);
      else pass_cnt++;
      i++;
    end
    total_cnt++;
    if (abort_cyc !== 7 || end_cyc !== abort_cyc + 1)
      $display("FAIL abort_run_idle abort %0d idle %0d required 7 and 8", abort_cyc, end_cyc);
    else pass_cnt++;
    total_cnt++;
    if ({end_r, end_c, end_h} !== '0) $display("FAIL abort_run_idx got %h required 0", {end_r, end_c, end_h});
    else pass_cnt++;
    late_done = 0;
    repeat (8) begin @(negedge clk); if (done || busy) late_done++; end
    total_cnt++;
    if (done_cnt + late_done != 0) $display("FAIL abort_run_done got %0d required 0", done_cnt + late_done);
    else pass_cnt++;
  endtask

  task automatic test_abort_flush();
    tup_t e, o;
    int i, late_done;
    push_expected(1, 1, 2);
    run(1, 1, 2, -1, 0, -1, 1, -1);
    total_cnt++;
    if (obs_q.size() != 12) $display("FAIL abort_fl_count got %0d required 12", obs_q.size());
    else pass_cnt++;
    i = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total_cnt++;
      if (o !== e) $display("FAIL abort_fl_tuple[%0d] got %h required %h", i, o, e);
      else pass_cnt++;
      i++;
    end
    total_cnt++;
    if (abort_cyc !== 13 || end_cyc !== 14)
      $display("FAIL abort_fl_idle abort %0d idle %0d required 13 and 14", abort_cyc, end_cyc);
    else pass_cnt++;
    late_done = 0;
    repeat (8) begin @(negedge clk); if (done || busy) late_done++; end
    total_cnt++;
    if (done_cnt + late_done != 0) $display("FAIL abort_fl_done got %0d required 0", done_cnt + late_done);
    else pass_cnt++;
  endtask

  task automatic test_start_ignored();
    tup_t e, o;
    int i;
    push_expected(1, 1, 2);
    run(1, 1, 2, -1, 0, -1, -1, 3);
    total_cnt++;
    if (obs_q.size() != 12) $display("FAIL restart_count got %0d required 12", obs_q.size());
    else pass_cnt++;
    i = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total_cnt++;
      if (o !== e) $display("FAIL restart_tuple[%0d] got %h required %h", i, o, e);
      else pass_cnt++;
      i++;
    end
    total_cnt++;
    if (done_cyc !== 16) $display("FAIL restart_done got %0d required 16", done_cyc);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    tup_t e, o;
    int i;
    @(posedge clk); #1;
    max_row = 8'd1; max_col = 8'd1; max_ch = 8'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total_cnt++;
    if (!(busy === 1'b1 && {row, col, ch} !== '0))
      $display("FAIL rst_mid_prep busy %0b idx %h required busy 1 and nonzero idx", busy, {row, col, ch});
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({busy, valid, first, last, done, row, col, ch} !== '0)
      $display("FAIL rst_mid_async got %h required 0", {busy, valid, first, last, done, row, col, ch});
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    push_expected(0, 0, 2);
    run(0, 0, 2, -1, 0, -1, -1, -1);
    total_cnt++;
    if (obs_q.size() != 3) $display("FAIL rst_mid_rerun_count got %0d required 3", obs_q.size());
    else pass_cnt++;
    i = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total_cnt++;
      if (o !== e) $display("FAIL rst_mid_tuple[%0d] got %h required %h", i, o, e);
      else pass_cnt++;
      i++;
    end
    total_cnt++;
    if (first_cyc !== 0 || done_cnt !== 1) $display("FAIL rst_mid_rerun first %0d done %0d required 0 and 1", first_cyc, done_cnt);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero_max();
    test_wrap_255();
    test_abort_run();
    test_abort_flush();
    test_start_ignored();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/conv_loop_scheduler.md
# conv_loop_scheduler

Sequences the three-level output loop nest (channel innermost, then column, then row) that drives the systolic PE array's operand fetch and accumulate logic. It latches a run configuration on `start_i`, emits one index tuple per non-stalled cycle, drains the datapath pipeline for a fixed number of cycles, and then signals completion. It sits between the layer-level control FSM and the per-cycle index and address generation of the array datapath.

## Interface
Parameters:
- `CNT_W`, 8: width of each loop index and each maximum.
- `DRAIN_CYCLES`, 4: cycles spent in `FLUSH` after the last tuple. The legal range is 0..255.

Ports:
- `clk_i`  in  1  clock. All state updates on the rising edge.
- `rst_n_i`  in  1  reset. Asynchronous assertion, active-low.
- `start_i`  in  1  starts a run. Sampled only in `IDLE`.
- `abort_i`  in  1  synchronous abort of the current run.
- `stall_i`  in  1  back-pressure from the datapath. Freezes the indices.
- `max_row_i`, `max_col_i`, `max_ch_i`  in  CNT_W each  inclusive last index for each loop. Latched on an accepted start.
- `busy_o`  out  1  high in any state other than `IDLE`.
- `valid_o`  out  1  the current index tuple is consumed this cycle.
- `row_o`, `col_o`, `ch_o`  out  CNT_W each  current indices (registered).
- `first_o`  out  1  marks the tuple (0,0,0) while `valid_o` is high.
- `last_o`  out  1  marks the tuple (max_row,max_col,max_ch) while `valid_o` is high.
- `done_o`  out  1  one-cycle completion pulse. Not asserted on abort.

## Operation
- FSM states: `IDLE`, `RUN`, `FLUSH`, `DONE`.
- `IDLE` → `RUN` on `start_i`.
  - Latch the three maxima.
  - Clear the indices to 0.
- `start_i` is ignored in every state other than `IDLE`.
- `RUN`:
  - `valid_o = !stall_i`. This is combinational from `stall_i`.
  - On each valid cycle, `ch` increments.
  - When `ch == max_ch`, `ch` wraps to 0 and `col` increments.
  - When `col` also wraps, `row` increments.
  - On a stalled cycle, all indices hold.
- Last tuple: on the valid cycle with all indices at their maxima, `last_o` is high.
  - Next state is `FLUSH`, or `DONE` if `DRAIN_CYCLES == 0`.
  - The indices return to 0.
- `FLUSH`:
  - The drain counter counts `DRAIN_CYCLES` cycles, then the FSM goes to `DONE`.
  - `stall_i` does not pause the drain counter.
  - `valid_o` is 0.
- `DONE`: `done_o` is 1 for this single cycle, then the FSM returns to `IDLE`.
- `abort_i` in `RUN` or `FLUSH`:
  - Next state is `IDLE` and the indices clear.
  - No `done_o` is issued.
  - `abort_i` has priority over `stall_i` and over last-tuple detection.
  - `abort_i` has no effect in `IDLE` or `DONE`.
- Total valid cycles per run = (max_row+1)·(max_col+1)·(max_ch+1).
- All maxima at 0 gives a single tuple with `first_o` and `last_o` both high.
- Maxima at all-ones must not overflow. The wrap is by comparison, not by carry-out.
- Arithmetic is unsigned, CNT_W bits. The drain counter is 8 bits.
- Changes on the `max_*_i` inputs during a run have no effect.

## Timing
- Reset values: FSM `IDLE`, `busy_o=0`, `valid_o=0`, `row_o=col_o=ch_o=0`, `first_o=0`, `last_o=0`, `done_o=0`.
- Start latency:
  - `start_i` is sampled high at edge k.
  - `busy_o` and `RUN` are active from edge k.
  - The first tuple is valid in the cycle after edge k, if not stalled.
- Throughput is one tuple per cycle with no bubbles at wrap points.
- Completion:
  - The last tuple is consumed at edge m.
  - `done_o` is high in cycle m+1+DRAIN_CYCLES.
  - `busy_o` falls at the following edge.
  - The earliest next start is sampled at the edge after that.
- Reset mid-run: the block asynchronously returns to the reset values above. No `done_o` is issued.

## Structure
- Shared package `sparhixcel_ctrl_pkg`:
  - the state enum `sched_state_t` (`IDLE`, `RUN`, `FLUSH`, `DONE`);
  - the default `CNT_W`.
- Sub-module `loop_level_counter`:
  - async active-low reset;
  - `clr`, `en`, and `max` inputs;
  - `count` and `at_max` outputs.
- Three `loop_level_counter` instances are chained. The enable of each outer counter is the AND of the inner counters' `at_max` and the step enable.
- FSM, drain counter and flag logic live at the top level.

## Test plan
- Maxima (row,col,ch)=(1,1,2), no stall: exactly 12 valid tuples in the order (0,0,0),(0,0,1),(0,0,2),(0,1,0)…(1,1,2).
  - `first_o` high on the 1st tuple only, `last_o` high on the 12th only.
  - `done_o` is 1 exactly 5 cycles after the last tuple with `DRAIN_CYCLES=4`.
- Same config with `stall_i` high for 3 cycles at tuple (0,1,1): indices hold and `valid_o=0` for those 3 cycles. The sequence is otherwise unchanged; `done_o` is delayed by 3 cycles.
- All maxima 0: one valid tuple (0,0,0) with `first_o=last_o=1`, followed by `done_o`. Repeat with maxima 255 for the inner loop and check the wrap from 255 to 0 without overflow.
- `abort_i` at tuple (1,0,1), and separately in `FLUSH`: `IDLE` next cycle, indices 0, `done_o` never asserted.
- `start_i` pulsed during `RUN` with different maxima: ignored. The tuple count matches the originally latched config.
- `rst_n_i` dropped mid-`RUN`: outputs reach reset values immediately without waiting for a clock edge. A new start after release runs normally from (0,0,0).
